mmio_id_tracker: RTL

- Closes the MMIO ID gap between the platform AXI-lite MMIO channel (mmio64_to_afu) and the Fletcher AxiTop s_axi slave. AxiTop carries no AXI IDs.
- Captures each accepted AR/AW ID in per-direction FIFOs and returns it on the matching R/B beat, in order.
- Gates AR/AW acceptance so that outstanding requests never exceed FIFO capacity.
- Sidecar on valid/ready/ID only. Address, W data, R data and resp are wired directly outside this block.

---
 rtl/mmio_id_tracker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mmio_id_tracker.sv
// mmio_id_tracker
//   Supplies AXI IDs for an ID-less MMIO slave. Each accepted AR/AW ID is
//   queued in a per-direction FIFO and returned on the matching R/B beat, in
//   order. AR/AW acceptance is gated so outstanding requests never exceed DEPTH.
//   Only valid/ready/ID are handled here; address, data and resp bypass it.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   s_arvalid/s_arid        AR request from platform; s_arready back to it
//   m_arvalid/m_arready     AR request forwarded to the slave
//   rvalid/rready, rid      R handshake observed; ID for the current R beat
//   s_awvalid/s_awid        AW request from platform; s_awready back to it
//   m_awvalid/m_awready     AW request forwarded to the slave
//   bvalid/bready, bid      B handshake observed; ID for the current B beat
//   rd_outstanding          read IDs currently held
//   wr_outstanding          write IDs currently held
//   err_orphan              sticky: response seen while its FIFO was empty
module mmio_id_tracker #(
  parameter int unsigned ID_WIDTH  = 9,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_arvalid,
  input  logic [ID_WIDTH-1:0]  s_arid,
  output logic                 s_arready,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic                 rvalid,
  input  logic                 rready,
  output logic [ID_WIDTH-1:0]  rid,
  input  logic                 s_awvalid,
  input  logic [ID_WIDTH-1:0]  s_awid,
  output logic                 s_awready,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  input  logic                 bvalid,
  input  logic                 bready,
  output logic [ID_WIDTH-1:0]  bid,
  output logic [CNT_WIDTH-1:0] rd_outstanding,
  output logic [CNT_WIDTH-1:0] wr_outstanding,
  output logic                 err_orphan
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned NUM_CH    = 2;

  // Channel 0 is the read tracker (AR->R), channel 1 the write tracker (AW->B)
  logic                 req_valid [NUM_CH];
  logic [ID_WIDTH-1:0]  req_id    [NUM_CH];
  logic                 fwd_ready [NUM_CH];
  logic                 acc_ready [NUM_CH];
  logic                 fwd_valid [NUM_CH];
  logic                 rsp_valid [NUM_CH];
  logic                 rsp_ready [NUM_CH];
  logic [ID_WIDTH-1:0]  rsp_id    [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt       [NUM_CH];
  logic                 orphan    [NUM_CH];

  assign req_valid[0] = s_arvalid;
  assign req_id[0]    = s_arid;
  assign fwd_ready[0] = m_arready;
  assign rsp_valid[0] = rvalid;
  assign rsp_ready[0] = rready;
  assign req_valid[1] = s_awvalid;
  assign req_id[1]    = s_awid;
  assign fwd_ready[1] = m_awready;
  assign rsp_valid[1] = bvalid;
  assign rsp_ready[1] = bready;

  assign s_arready      = acc_ready[0];
  assign m_arvalid      = fwd_valid[0];
  assign rid            = rsp_id[0];
  assign rd_outstanding = cnt[0];
  assign s_awready      = acc_ready[1];
  assign m_awvalid      = fwd_valid[1];
  assign bid            = rsp_id[1];
  assign wr_outstanding = cnt[1];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_trk
    logic [ID_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] rptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 full;
    logic                 push;
    logic                 pop;

    // Gating uses only the registered count; a same-cycle pop does not free a slot
    assign full          = (count == CNT_WIDTH'(DEPTH));
    assign acc_ready[g]  = reset_n & fwd_ready[g] & ~full;
    assign fwd_valid[g]  = reset_n & req_valid[g] & ~full;
    assign push          = req_valid[g] & acc_ready[g];
    assign pop           = rsp_valid[g] & rsp_ready[g] & (count != '0);
    assign orphan[g]     = rsp_valid[g] & rsp_ready[g] & (count == '0);
    assign cnt[g]        = count;
    // Empty (or in reset) reads zero so no stale or X ID leaks out
    assign rsp_id[g]     = (reset_n && count != '0) ? mem[rptr] : '0;

    // ID storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wptr] <= req_id[g];
      end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_WIDTH'(1);
        if (pop)  rptr <= rptr + PTR_WIDTH'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_WIDTH'(1);
          2'b01:   count <= count - CNT_WIDTH'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Sticky orphan flag shared by both directions
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_orphan <= 1'b0;
    end else if (orphan[0] || orphan[1]) begin
      err_orphan <= 1'b1;
    end
  end

endmodule
